// File: rtl/qpix_cfg_pkg.sv
// Shared types and constants for the QPix configuration sequencer.
package qpix_cfg_pkg;

  // Transaction FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StGap,
    StLatch,
    StDone
  } cfg_state_e;

  // Silicon defaults (50 MHz system clock).
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefClkDiv   = 25;
  localparam int unsigned DefLoadCyc  = 4;
  localparam int unsigned DefPulseCyc = 5000;

  // Short timings for simulation builds.
  localparam int unsigned SimClkDiv   = 2;
  localparam int unsigned SimLoadCyc  = 2;
  localparam int unsigned SimPulseCyc = 10;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qpix_cfg_shifter.sv
// Shift engine: 32-bit MSB-first shift register, bit counter and
// serial-clock half-period divider.
module qpix_cfg_shifter
  import qpix_cfg_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,    // snapshot word, clear counters
  input  logic [DATA_W-1:0] word,
  input  logic              div_en,   // run the half-period divider
  input  logic              advance,  // shift out one bit
  output logic              msb,
  output logic              half_tc,  // last cycle of a half period
  output logic              last_bit  // bit DATA_W-1 is on the line
);

  localparam int unsigned BitW = cnt_w(DATA_W);
  localparam int unsigned DivW = cnt_w(CLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DATA_W-1:0] shreg_q;
  logic [BitW-1:0]   bit_q;
  logic [DivW-1:0]   div_q;

  assign msb      = shreg_q[DATA_W-1];
  assign half_tc  = (div_q == DivLast);
  assign last_bit = (bit_q == BitLast);

  // Shift register: zero fill, so it is all-zero after a full word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (start) begin
      shreg_q <= word;
    end else if (advance) begin
      shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
    end
  end

  // Bit counter saturates on the last bit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= '0;
    end else if (start) begin
      bit_q <= '0;
    end else if (advance && !last_bit) begin
      bit_q <= bit_q + 1'b1;
    end
  end

  // Half-period divider, terminal-compared and reloaded to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (start) begin
      div_q <= '0;
    end else if (div_en) begin
      div_q <= half_tc ? '0 : div_q + 1'b1;
    end
  end

endmodule

// File: rtl/qpix_cfg_sequencer.sv
// Sequences the two QPix serial configuration interfaces: request capture,
// round-robin arbitration and the load/shift/latch transaction FSM.
module qpix_cfg_sequencer
  import qpix_cfg_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned LOAD_CYC  = DefLoadCyc,
  parameter int unsigned PULSE_CYC = DefPulseCyc
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        def_sel,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        done,
  output logic [1:0]        sclk,
  output logic [1:0]        sdo,
  output logic [1:0]        sel_def,
  output logic [1:0]        load_data
);

  // One counter serves both the LOAD hold and the loadData pulse.
  localparam int unsigned PhMax = (PULSE_CYC > LOAD_CYC) ? PULSE_CYC : LOAD_CYC;
  localparam int unsigned PhW   = cnt_w(PhMax + 1);
  localparam logic [PhW-1:0] LoadLast  = PhW'(LOAD_CYC - 1);
  localparam logic [PhW-1:0] PulseLast = PhW'(PULSE_CYC - 1);

  cfg_state_e      state_q;
  logic [1:0]      grant_q;
  logic            last_q;
  logic [PhW-1:0]  phase_q;
  logic            sclk_q;
  logic            sel_def_q;
  logic            ld_q;
  logic [1:0]      done_q;
  logic [1:0]      req_q;
  logic [1:0]      pending_q;

  logic            win_idx;
  logic [1:0]      grant_now;
  logic            start;
  logic            div_en;
  logic            advance;
  logic            shift_msb;
  logic            half_tc;
  logic            last_bit;

  // Round-robin pick; only acts from IDLE.
  always_comb begin
    win_idx = last_q;
    if (pending_q == 2'b11) begin
      win_idx = ~last_q;
    end else if (pending_q[0]) begin
      win_idx = 1'b0;
    end else if (pending_q[1]) begin
      win_idx = 1'b1;
    end
    grant_now = 2'b00;
    if (state_q == StIdle && pending_q != 2'b00) begin
      grant_now = win_idx ? 2'b10 : 2'b01;
    end
  end

  // Rising-edge request capture; a new edge beats the grant clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= req;
      pending_q <= (pending_q & ~grant_now) | (req & ~req_q);
    end
  end

  // Shift engine controls decoded from the current state.
  always_comb begin
    start   = (grant_now != 2'b00) && !def_sel[win_idx];
    div_en  = (state_q == StShiftLo) || (state_q == StShiftHi) || (state_q == StGap);
    advance = (state_q == StShiftHi) && half_tc;
  end

  qpix_cfg_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .word     (win_idx ? data1 : data0),
    .div_en   (div_en),
    .advance  (advance),
    .msb      (shift_msb),
    .half_tc  (half_tc),
    .last_bit (last_bit)
  );

  // Transaction FSM with registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= 1'b1;
      phase_q   <= '0;
      sclk_q    <= 1'b0;
      sel_def_q <= 1'b0;
      ld_q      <= 1'b0;
      done_q    <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_now != 2'b00) begin
            grant_q   <= grant_now;
            last_q    <= win_idx;
            phase_q   <= '0;
            sel_def_q <= def_sel[win_idx];
            if (def_sel[win_idx]) begin
              ld_q    <= 1'b1;
              state_q <= StLatch;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (phase_q == LoadLast) begin
            phase_q <= '0;
            state_q <= StShiftLo;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StShiftLo: begin
          if (half_tc) begin
            sclk_q  <= 1'b1;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (half_tc) begin
            sclk_q  <= 1'b0;
            state_q <= last_bit ? StGap : StShiftLo;
          end
        end
        StGap: begin
          if (half_tc) begin
            ld_q    <= 1'b1;
            phase_q <= '0;
            state_q <= StLatch;
          end
        end
        StLatch: begin
          if (phase_q == PulseLast) begin
            ld_q    <= 1'b0;
            state_q <= StDone;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StDone: begin
          done_q    <= grant_q;
          grant_q   <= '0;
          sel_def_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-interface gating: the idle interface sees all zeros.
  always_comb begin
    grant     = grant_q;
    busy      = (grant_q != 2'b00);
    done      = done_q;
    sclk      = grant_q & {2{sclk_q}};
    sdo       = grant_q & {2{shift_msb}};
    sel_def   = grant_q & {2{sel_def_q}};
    load_data = grant_q & {2{ld_q}};
  end

endmodule
